dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Three-port arbiter in front of a single-port data RAM. Port 0 is the CPU,
//   port 1 the VGA fetch and port 2 the input logger.
//   Winners are picked round-robin. A winner holding lock keeps the RAM for a
//   burst of at most LOCK_MAX grants.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   req/we/lock [2:0]   : per-port request, write enable (1 = write), burst lock
//   addr  [3*ADDR_W-1:0]: per-port word address, port k at [k*ADDR_W +: ADDR_W]
//   wdata [95:0]        : per-port write data, port k at [k*32 +: 32]
//   gnt   [2:0]         : one-hot-or-zero grant, combinational
//   rvalid[2:0], rdata  : read return, one cycle after a read grant
//   ram_wEn/ram_addr/ram_dataIn : RAM request, muxed from the granted port
//   ram_dataOut         : RAM read data, one cycle after the address
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [2:0]            lock,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [95:0]           wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [31:0]           rdata,
  output logic                  ram_wEn,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [31:0]           ram_dataIn,
  input  logic [31:0]           ram_dataOut
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       owner, owner_nx;
  logic [CNT_W-1:0] burst, burst_nx;
  logic             force_rel, force_rel_nx;
  logic [2:0]       gnt_c;
  logic [2:0]       rvalid_q;
  logic [1:0]       win;
  logic             win_vld;
  logic [1:0]       cand;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    owner_nx     = owner;
    burst_nx     = burst;
    force_rel_nx = 1'b0;
    gnt_c        = '0;
    win          = '0;
    win_vld      = 1'b0;
    cand         = ptr;

    if (state == LOCKED && req[owner] && lock[owner]) begin
      // The burst continues. Only the owner is served.
      win      = owner;
      win_vld  = 1'b1;
      burst_nx = burst + 1'b1;
      if (burst_nx == CNT_W'(LOCK_MAX)) begin
        state_nx     = ARB;
        force_rel_nx = 1'b1;
      end
    end else begin
      // Arbitrate round-robin. A lock drop lands here in the same cycle, with
      // ptr still equal to the owner.
      state_nx = ARB;
      for (int i = 0; i < 3; i++) begin
        cand = next_port(cand);
        if (!win_vld && req[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
      if (win_vld) begin
        ptr_nx = win;
        // After a forced release, the previous owner cannot relock at once.
        if (lock[win] && !(force_rel && win == owner)) begin
          owner_nx = win;
          burst_nx = CNT_W'(1);
          if (LOCK_MAX <= 1) force_rel_nx = 1'b1;
          else               state_nx     = LOCKED;
        end
      end
    end

    if (win_vld && !reset) gnt_c[win] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB;
      ptr       <= 2'd2;
      owner     <= 2'd0;
      burst     <= '0;
      force_rel <= 1'b0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      burst     <= burst_nx;
      force_rel <= force_rel_nx;
      rvalid_q  <= gnt_c & ~we;
    end
  end

  assign gnt        = gnt_c;
  assign ram_wEn    = |gnt_c & we[win];
  assign ram_addr   = |gnt_c ? addr[int'(win)*ADDR_W +: ADDR_W] : '0;
  assign ram_dataIn = |gnt_c ? wdata[int'(win)*32 +: 32] : '0;

  // A read in flight when reset arrives is dropped at the output. The RAM
  // answers one cycle after the address, so rdata passes straight through.
  assign rvalid = rvalid_q & {3{~reset}};
  assign rdata  = |rvalid ? ram_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int ADDR_W   = 12;
  localparam int LOCK_MAX = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic [2:0]          req, we, lock;
  logic [3*ADDR_W-1:0] addr;
  logic [95:0]         wdata;
  logic [2:0]          gnt, rvalid;
  logic [31:0]         rdata;
  logic                ram_wEn;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_dataIn;
  logic [31:0]         ram_dataOut;

  dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  always #5 clock = ~clock;

  // RAM with one-cycle read latency.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    ram_dataOut = '0;
  end
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]        g;
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } gexp_t;
  typedef struct {
    int          stamp;
    logic [2:0]  port;
    logic [31:0] data;
  } rexp_t;
  gexp_t exp_g[$];
  rexp_t exp_r[$];

  // Reference model state.
  int          m_last, m_owner, m_burst, m_norelock;
  logic [31:0] m_mem [int];

  // Drive one cycle and predict it. The model works from the arbitration
  // rules directly: last winner, current burst owner and grants used.
  task automatic step(input logic rst, input logic [2:0] r, w, l,
                      input logic [3*ADDR_W-1:0] a, input logic [95:0] d,
                      output logic [2:0] g);
    int win, ign, ai;
    gexp_t e;
    @(negedge clock);
    reset = rst; req = r; we = w; lock = l; addr = a; wdata = d;
    cyc++;
    win = -1;
    if (rst) begin
      m_last = 2; m_owner = -1; m_burst = 0; m_norelock = -1;
      exp_r.delete();
    end else if (m_owner >= 0 && r[m_owner] && l[m_owner]) begin
      win = m_owner;
      m_burst++;
      if (m_burst == LOCK_MAX) begin
        m_norelock = m_owner;
        m_owner    = -1;
      end
    end else begin
      ign = m_norelock;
      m_norelock = -1;
      m_owner = -1;
      for (int i = 1; i <= 3; i++)
        if (win < 0 && r[(m_last + i) % 3]) win = (m_last + i) % 3;
      if (win >= 0) begin
        m_last = win;
        if (l[win] && win != ign) begin
          m_owner = win; m_burst = 1;
          if (LOCK_MAX == 1) begin m_norelock = win; m_owner = -1; end
        end
      end
    end
    e = '{g: 3'b000, w: 1'b0, a: '0, d: '0};
    if (win >= 0) begin
      e.g = 3'b001 << win;
      e.w = w[win];
      e.a = a[win*ADDR_W +: ADDR_W];
      e.d = d[win*32 +: 32];
      ai  = int'(e.a);
      if (e.w) m_mem[ai] = e.d;
      else exp_r.push_back('{stamp: cyc + 1, port: e.g,
                             data: m_mem.exists(ai) ? m_mem[ai] : 32'h0});
    end
    exp_g.push_back(e);
    g = e.g;
  endtask

  // Monitor: compare the request side every cycle and each read return.
  initial begin
    gexp_t e;
    rexp_t x;
    forever begin
      @(negedge clock);
      #2;
      if (exp_g.size() > 0) begin
        e = exp_g.pop_front();
        check("gnt", 64'(gnt), 64'(e.g));
        check("ram_wEn", 64'(ram_wEn), 64'(e.w));
        check("ram_addr", 64'(ram_addr), 64'(e.a));
        check("ram_dataIn", 64'(ram_dataIn), 64'(e.d));
      end
      if (rvalid !== 3'b000) begin
        if (exp_r.size() == 0) begin
          check("unexpected_rvalid", 64'(rvalid), 64'(0));
        end else begin
          x = exp_r.pop_front();
          check("rvalid_port", 64'(rvalid), 64'(x.port));
          check("rvalid_latency", 64'(cyc), 64'(x.stamp));
          check("rdata", 64'(rdata), 64'(x.data));
        end
      end else if (exp_r.size() > 0 && exp_r[0].stamp <= cyc) begin
        x = exp_r.pop_front();
        check("missing_rvalid", 64'(rvalid), 64'(x.port));
      end else begin
        check("rdata_idle", 64'(rdata), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3*ADDR_W-1:0] mk_a(input int a2, a1, a0);
    return {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  // Directed cycle with a literal expected grant.
  task automatic dstep(input string name, input logic rst, input logic [2:0] r, w, l,
                       input logic [3*ADDR_W-1:0] a, input logic [95:0] d,
                       input logic [2:0] exp_gnt);
    logic [2:0] g;
    step(rst, r, w, l, a, d, g);
    #2;
    check(name, 64'(gnt), 64'(exp_gnt));
  endtask

  initial begin
    logic [2:0]        g, pend, pw, lk;
    logic [ADDR_W-1:0] pa [3];
    logic [31:0]       pd [3];
    logic [3*ADDR_W-1:0] av;
    logic [95:0]       dv;
    logic [2:0]        burst_seq [12];
    logic              rst;

    reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    m_last = 2; m_owner = -1; m_burst = 0; m_norelock = -1;

    // Reset: no grant and no RAM traffic, even with all ports requesting.
    dstep("reset_gnt", 1, 3'b111, 3'b111, 3'b000, mk_a(1, 2, 3), {3{32'h1}}, 3'b000);
    check("reset_wen", 64'(ram_wEn), 64'(0));
    check("reset_addr", 64'(ram_addr), 64'(0));
    check("reset_rvalid", 64'(rvalid), 64'(0));

    // Round-robin over three readers.
    dstep("rr0", 0, 3'b111, 3'b000, 3'b000, mk_a(0, 0, 0), '0, 3'b001);
    dstep("rr1", 0, 3'b111, 3'b000, 3'b000, mk_a(0, 0, 0), '0, 3'b010);
    dstep("rr2", 0, 3'b111, 3'b000, 3'b000, mk_a(0, 0, 0), '0, 3'b100);
    dstep("rr3", 0, 3'b111, 3'b000, 3'b000, mk_a(0, 0, 0), '0, 3'b001);

    // Write from port 1, then read it back on port 0.
    dstep("wr_gnt", 0, 3'b010, 3'b010, 3'b000, mk_a(0, 5, 0), {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010);
    check("wr_wen", 64'(ram_wEn), 64'(1));
    dstep("rd_gnt", 0, 3'b001, 3'b000, 3'b000, mk_a(0, 0, 5), '0, 3'b001);
    dstep("idle", 0, 3'b000, 3'b000, 3'b000, '0, '0, 3'b000);
    check("rd_rvalid", 64'(rvalid), 64'(3'b001));
    check("rd_rdata", 64'(rdata), 64'(32'hDEADBEEF));

    // Port 2 locked for 12 cycles against ports 0 and 1. The ptr=1 setup lets
    // port 2 win first.
    dstep("pre_lock", 0, 3'b010, 3'b000, 3'b000, '0, '0, 3'b010);
    for (int i = 0; i < 12; i++) burst_seq[i] = 3'b100;
    burst_seq[8] = 3'b001;
    burst_seq[9] = 3'b010;
    for (int i = 0; i < 12; i++)
      dstep($sformatf("burst%0d", i), 0, 3'b111, 3'b000, 3'b100, mk_a(9, 8, 7), '0, burst_seq[i]);

    // Port 0 drops lock after 3 locked grants. Port 1 wins in the same cycle.
    dstep("pre_drop", 0, 3'b100, 3'b000, 3'b000, '0, '0, 3'b100);
    dstep("drop0", 0, 3'b011, 3'b000, 3'b001, '0, '0, 3'b001);
    dstep("drop1", 0, 3'b011, 3'b000, 3'b001, '0, '0, 3'b001);
    dstep("drop2", 0, 3'b011, 3'b000, 3'b001, '0, '0, 3'b001);
    dstep("drop_now", 0, 3'b011, 3'b000, 3'b000, '0, '0, 3'b010);

    // Port 1 withdraws while port 0 holds the lock.
    dstep("wd_lock", 0, 3'b001, 3'b000, 3'b001, '0, '0, 3'b001);
    dstep("wd_req", 0, 3'b011, 3'b000, 3'b001, '0, '0, 3'b001);
    dstep("wd_gone", 0, 3'b001, 3'b000, 3'b001, '0, '0, 3'b001);
    dstep("wd_idle", 0, 3'b000, 3'b000, 3'b000, '0, '0, 3'b000);
    dstep("wd_after", 0, 3'b011, 3'b010, 3'b000, '0, '0, 3'b010);

    // Reset arrives the cycle after a read grant.
    dstep("rst_rd", 0, 3'b001, 3'b000, 3'b000, mk_a(0, 0, 5), '0, 3'b001);
    dstep("rst_mid", 1, 3'b111, 3'b000, 3'b000, '0, '0, 3'b000);
    check("rst_rvalid", 64'(rvalid), 64'(0));
    dstep("rst_hold", 1, 3'b111, 3'b000, 3'b001, '0, '0, 3'b000);
    dstep("rst_first", 0, 3'b111, 3'b000, 3'b000, '0, '0, 3'b001);
    check("rst_no_rvalid", 64'(rvalid), 64'(0));

    // Random traffic. Pending requests hold their fields until granted.
    pend = '0; pw = '0; lk = '0;
    for (int p = 0; p < 3; p++) begin pa[p] = '0; pd[p] = '0; end
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int p = 0; p < 3; p++) begin
        if (pend[p]) begin
          if ($urandom_range(0, 15) == 0) pend[p] = 1'b0;
        end else if ($urandom_range(0, 3) < (lk[p] ? 3 : 1)) begin
          pend[p] = 1'b1;
          pw[p]   = 1'($urandom_range(0, 1));
          pa[p]   = ADDR_W'($urandom_range(0, 15));
          pd[p]   = $urandom;
        end
        if ($urandom_range(0, 7) == 0) lk[p] = ~lk[p];
      end
      av = {pa[2], pa[1], pa[0]};
      dv = {pd[2], pd[1], pd[0]};
      step(rst, pend, pw, lk, av, dv, g);
      pend = rst ? 3'b000 : (pend & ~g);
    end

    for (int i = 0; i < 4; i++) step(0, 3'b000, 3'b000, 3'b000, '0, '0, g);
    #4;
    check("reads_drained", 64'(exp_r.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
